// File: rtl/mem_arbiter.sv
// Two-port byte memory arbiter: one transfer at a time, optional owner lock.
// Define ARB_ROUNDROBIN_EN to alternate grants on contention; otherwise port 0 wins.
module mem_arbiter #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [addr_width-1:0] m0_addr,
    input  logic [addr_width-1:0] m1_addr,
    input  logic [7:0]            m0_wdata,
    input  logic [7:0]            m1_wdata,
    input  logic                  m0_lock,
    input  logic                  m1_lock,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic [7:0]            m0_rdata,
    output logic [7:0]            m1_rdata,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ACK} state_t;

    state_t                  state;
    logic                    lock_hold;
    logic                    elig0;
    logic                    elig1;
    logic                    grant_valid;
    logic                    grant;
    logic                    sel_we;
    logic [addr_width-1:0]   sel_addr;
    logic [7:0]              sel_wdata;

    // While a lock is held only the current owner may be granted.
    always_comb begin
        elig0 = m0_req;
        elig1 = m1_req;
        if (lock_hold) begin
            elig0 = m0_req && !owner;
            elig1 = m1_req && owner;
        end
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
`ifdef ARB_ROUNDROBIN_EN
            grant = ~owner;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = elig1;
        end
        sel_we    = grant ? m1_we    : m0_we;
        sel_addr  = grant ? m1_addr  : m0_addr;
        sel_wdata = grant ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lock_hold   <= 1'b0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_hold && !(owner ? m1_req : m0_req)) begin
                        lock_hold <= 1'b0;
                    end
                    if (grant_valid) begin
                        owner <= grant;
                        busy  <= 1'b1;
                        if (sel_we) begin
                            mem_waddr   <= sel_addr;
                            mem_data_in <= sel_wdata;
                            mem_write   <= 1'b1;
                            state       <= WR;
                        end else begin
                            mem_raddr <= sel_addr;
                            state     <= RD1;
                        end
                    end
                end
                WR: begin
                    mem_write <= 1'b0;
                    if (owner) m1_ack <= 1'b1;
                    else       m0_ack <= 1'b1;
                    state <= ACK;
                end
                RD1: begin
                    state <= RD2;
                end
                // Memory read data has had two cycles to settle since mem_raddr moved.
                RD2: begin
                    if (owner) begin
                        m1_rdata <= mem_data_out;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= mem_data_out;
                        m0_ack   <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    m0_ack    <= 1'b0;
                    m1_ack    <= 1'b0;
                    busy      <= 1'b0;
                    lock_hold <= owner ? m1_lock : m0_lock;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transfers plus contention, lock and reset sequences.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [8:0] m0_addr = '0, m1_addr = '0;
    logic [7:0] m0_wdata = '0, m1_wdata = '0;
    logic       m0_lock = 0, m1_lock = 0;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [8:0] mem_raddr, mem_waddr;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       busy, owner;

    mem_arbiter #(.addr_width(9)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Byte memory with one registered read stage, preloaded while reset is low.
    logic [7:0] tb_mem [512];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= 8'h00;
            tb_mem[9'h1FF] <= 8'h3C;
            tb_mem[9'h100] <= 8'h99;
            mem_data_out   <= 8'h00;
        end else begin
            if (mem_write) tb_mem[mem_waddr] <= mem_data_in;
            mem_data_out <= tb_mem[mem_raddr];
        end
    end

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        bit         port;
        bit         we;
        logic [8:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rdata;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    logic [7:0] last_rd[2];
    bit         rr_exp[4];
    int         n_vec = 0;
    int         n_miss = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_vec++;
        n_miss++;
        $display("[TB] FAIL %s: got no ack within budget, wanted ack", name);
    endtask

    // Wait (bounded) for an ack, then pop the scoreboard and compare.
    task automatic waitAck(output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(m0_ack || m1_ack) && cyc < 12);
        if (!(m0_ack || m1_ack)) begin
            failNow("ack_timeout");
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL unexpected_ack: got ack %b%b, wanted none", m1_ack, m0_ack);
        end else begin
            e = sb.pop_front();
            checkOutput("ack_port", 32'({m1_ack, m0_ack}), e.port ? 2 : 1);
            checkOutput("owner_at_ack", 32'(owner), 32'(e.port));
            if (!e.we) last_rd[e.port] = e.rdata;
            checkOutput("m0_rdata", 32'(m0_rdata), 32'(last_rd[0]));
            checkOutput("m1_rdata", 32'(m1_rdata), 32'(last_rd[1]));
        end
    endtask

    task automatic applyStimulus(input bit port, input bit we, input logic [8:0] addr,
                                 input logic [7:0] wdata, input int exp_lat, input logic [7:0] exp_rd);
        int cyc;
        @(negedge clk);
        if (port) begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end
        sb.push_back('{port: port, we: we, rdata: exp_rd});
        @(negedge clk);
        checkOutput("busy_after_grant", 32'(busy), 1);
        checkOutput("owner_after_grant", 32'(owner), 32'(port));
        checkOutput("ack_early", 32'(m0_ack | m1_ack), 0);
        if (we) begin
            checkOutput("mem_write_high", 32'(mem_write), 1);
            checkOutput("mem_waddr", 32'(mem_waddr), 32'(addr));
            checkOutput("mem_data_in", 32'(mem_data_in), 32'(wdata));
        end else begin
            checkOutput("mem_raddr", 32'(mem_raddr), 32'(addr));
            checkOutput("mem_write_on_read", 32'(mem_write), 0);
        end
        waitAck(cyc);
        checkOutput("ack_latency", cyc + 1, exp_lat);
        if (we) checkOutput("mem_write_one_cycle", 32'(mem_write), 0);
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{port: 0, we: 1, addr: 9'h005, wdata: 8'hA5, lat: 2, rdata: 8'h00};
        vecs[1] = '{port: 1, we: 0, addr: 9'h1FF, wdata: 8'h00, lat: 3, rdata: 8'h3C};
        vecs[2] = '{port: 0, we: 0, addr: 9'h005, wdata: 8'h00, lat: 3, rdata: 8'hA5};
        vecs[3] = '{port: 1, we: 1, addr: 9'h000, wdata: 8'h5A, lat: 2, rdata: 8'h00};
        vecs[4] = '{port: 0, we: 0, addr: 9'h000, wdata: 8'h00, lat: 3, rdata: 8'h5A};
        vecs[5] = '{port: 1, we: 1, addr: 9'h1FF, wdata: 8'hC3, lat: 2, rdata: 8'h00};
        vecs[6] = '{port: 0, we: 0, addr: 9'h1FF, wdata: 8'h00, lat: 3, rdata: 8'hC3};
        vecs[7] = '{port: 1, we: 0, addr: 9'h100, wdata: 8'h00, lat: 3, rdata: 8'h99};
`ifdef ARB_ROUNDROBIN_EN
        rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0; rr_exp[3] = 1;
`else
        rr_exp[0] = 0; rr_exp[1] = 0; rr_exp[2] = 0; rr_exp[3] = 0;
`endif
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_owner", 32'(owner), 0);
        checkOutput("rst_acks", 32'({m1_ack, m0_ack}), 0);
        checkOutput("rst_mem_write", 32'(mem_write), 0);
        checkOutput("rst_raddr", 32'(mem_raddr), 0);
        checkOutput("rst_rdata", 32'({m1_rdata, m0_rdata}), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata);
        end

        // Contention: both ports hold write requests for four transfers.
        @(negedge clk);
        m0_we = 1; m0_addr = 9'h010; m0_wdata = 8'h10; m0_req = 1;
        m1_we = 1; m1_addr = 9'h020; m1_wdata = 8'h20; m1_req = 1;
        for (int i = 0; i < 4; i++) sb.push_back('{port: rr_exp[i], we: 1'b1, rdata: 8'h00});
        for (int i = 0; i < 4; i++) waitAck(cyc);
        m0_req = 0; m1_req = 0;

        // Lock: m1 keeps ownership for four writes while m0 waits to read the last one back.
        @(negedge clk);
        @(negedge clk);
        m1_we = 1; m1_addr = 9'h030; m1_wdata = 8'h41; m1_lock = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) sb.push_back('{port: 1'b1, we: 1'b1, rdata: 8'h00});
        sb.push_back('{port: 1'b0, we: 1'b0, rdata: 8'h44});
        @(negedge clk);
        checkOutput("lock_first_owner", 32'(owner), 1);
        m0_we = 0; m0_addr = 9'h033; m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            waitAck(cyc);
            if (i < 3) begin
                m1_addr = 9'(9'h031 + i);
                m1_wdata = 8'(8'h42 + i);
            end else begin
                m1_lock = 0;
                m1_req = 0;
            end
        end
        waitAck(cyc);
        m0_req = 0;

        // Reset asserted while a read sits in RD2.
        @(negedge clk);
        @(negedge clk);
        m1_we = 0; m1_addr = 9'h1FF; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m1_req = 0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_acks", 32'({m1_ack, m0_ack}), 0);
        checkOutput("mid_rst_mem_write", 32'(mem_write), 0);
        checkOutput("mid_rst_owner", 32'(owner), 0);
        checkOutput("mid_rst_raddr", 32'(mem_raddr), 0);
        checkOutput("mid_rst_waddr", 32'(mem_waddr), 0);
        checkOutput("mid_rst_data_in", 32'(mem_data_in), 0);
        checkOutput("mid_rst_rdata", 32'({m1_rdata, m0_rdata}), 0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_ack", 32'({m1_ack, m0_ack, busy}), 0);
        end
        applyStimulus(1'b0, 1'b0, 9'h1FF, 8'h00, 3, 8'h3C);
        applyStimulus(1'b1, 1'b1, 9'h002, 8'h77, 2, 8'h00);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
